// File: rtl/persp_divide.sv
//==============================================================================
// Module      : persp_divide
// Description : Perspective-divide stage placed in front of a shared AXI-stream
//               divider. Accepts one homogeneous vertex (x, y, z, w) in
//               signed fixed point and sends x/w, y/w and z/w through the
//               divider one at a time. Each quotient is saturated back to the
//               fixed-point word, and the results go out as (x', y', z').
//
// Ports       : aclk, aresetn (async, active-low)
//               s_*        input vertex stream (x, y, z, w)
//               div_*      dividend / divisor / quotient streams to the divider
//               m_*        result stream (x', y', z') to rasteriser setup
//               m_sat[2:0] per-coordinate clamp flags
//                          (present only with PERSP_DIVIDE_SAT_FLAG_EN)
//
// Config      : `define PERSP_DIVIDE_SAT_FLAG_EN adds the m_sat output port.
//               Without it the port and flag logic are absent and the
//               datapath is unchanged.
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module persp_divide #(
    parameter int WIDTH      = 32,
    parameter int FRAC_BITS  = 16,
    parameter int DIVIDEND_W = 48   // must equal WIDTH + FRAC_BITS
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [WIDTH-1:0]      s_x,
    input  logic [WIDTH-1:0]      s_y,
    input  logic [WIDTH-1:0]      s_z,
    input  logic [WIDTH-1:0]      s_w,

    output logic                  div_dividend_tvalid,
    input  logic                  div_dividend_tready,
    output logic [DIVIDEND_W-1:0] div_dividend_tdata,
    output logic                  div_divisor_tvalid,
    input  logic                  div_divisor_tready,
    output logic [WIDTH-1:0]      div_divisor_tdata,
    input  logic                  div_dout_tvalid,
    output logic                  div_dout_tready,
    input  logic [DIVIDEND_W-1:0] div_dout_tdata,

    output logic                  m_tvalid,
    input  logic                  m_tready,
`ifdef PERSP_DIVIDE_SAT_FLAG_EN
    output logic [2:0]            m_sat,
`endif
    output logic [WIDTH-1:0]      m_x,
    output logic [WIDTH-1:0]      m_y,
    output logic [WIDTH-1:0]      m_z
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_max_val = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min_val = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [1:0]       r_k;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_w;
    logic             r_dvd_valid;
    logic             r_dvs_valid;
    logic             r_dvd_sent;
    logic             r_dvs_sent;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_mx;
    logic [WIDTH-1:0] r_my;
    logic [WIDTH-1:0] r_mz;

    // Zero-divide result: the sign of the numerator picks the rail.
    function automatic logic [WIDTH-1:0] f_zdiv(input logic [WIDTH-1:0] c);
        if (c == '0)
            return '0;
        else if (c[WIDTH-1])
            return c_min_val;
        else
            return c_max_val;
    endfunction

    // Coordinate currently being divided
    logic [WIDTH-1:0] w_coord;
    always_comb begin
        w_coord = r_x;
        case (r_k)
            2'd1:    w_coord = r_y;
            2'd2:    w_coord = r_z;
            default: w_coord = r_x;
        endcase
    end

    // Concatenating FRAC_BITS zeros is the sign-extend-then-shift of the
    // numerator: the coordinate's sign bit lands on the dividend's MSB.
    assign div_dividend_tdata  = {w_coord, {FRAC_BITS{1'b0}}};
    assign div_divisor_tdata   = r_w;
    assign div_dividend_tvalid = r_dvd_valid;
    assign div_divisor_tvalid  = r_dvs_valid;
    assign div_dout_tready     = (r_state != ST_OUTPUT);
    assign s_tready            = (r_state == ST_IDLE);
    assign m_tvalid            = r_m_valid;
    assign m_x                 = r_mx;
    assign m_y                 = r_my;
    assign m_z                 = r_mz;

    // The quotient fits the word only when every bit from WIDTH-1 upward
    // matches the sign; otherwise clamp toward the quotient's sign.
    logic             w_hi_ones;
    logic             w_hi_zeros;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat_val;
    assign w_hi_ones  = &div_dout_tdata[DIVIDEND_W-1:WIDTH-1];
    assign w_hi_zeros = ~|div_dout_tdata[DIVIDEND_W-1:WIDTH-1];
    assign w_ovf      = ~(w_hi_ones | w_hi_zeros);
    assign w_sat_val  = w_ovf ? (div_dout_tdata[DIVIDEND_W-1] ? c_min_val : c_max_val)
                              : div_dout_tdata[WIDTH-1:0];

    logic w_q_take;
    assign w_q_take = (r_state == ST_WAIT) && div_dout_tvalid;

`ifdef PERSP_DIVIDE_SAT_FLAG_EN
    logic [2:0] r_sat;
    assign m_sat = r_sat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sat <= 3'b000;
        end else if (r_state == ST_IDLE && s_tvalid) begin
            // A zero numerator over w==0 yields 0, which is not a clamp.
            if (s_w == '0)
                r_sat <= {(s_z != '0), (s_y != '0), (s_x != '0)};
            else
                r_sat <= 3'b000;
        end else if (w_q_take) begin
            r_sat[r_k] <= w_ovf;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_k         <= 2'd0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_w         <= '0;
            r_dvd_valid <= 1'b0;
            r_dvs_valid <= 1'b0;
            r_dvd_sent  <= 1'b0;
            r_dvs_sent  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_mx        <= '0;
            r_my        <= '0;
            r_mz        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_tvalid) begin
                        r_x <= s_x;
                        r_y <= s_y;
                        r_z <= s_z;
                        r_w <= s_w;
                        if (s_w == '0) begin
                            r_mx      <= f_zdiv(s_x);
                            r_my      <= f_zdiv(s_y);
                            r_mz      <= f_zdiv(s_z);
                            r_m_valid <= 1'b1;
                            r_state   <= ST_OUTPUT;
                        end else begin
                            r_k         <= 2'd0;
                            r_dvd_valid <= 1'b1;
                            r_dvs_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Each channel drops tvalid after its own handshake so
                    // the operand is never offered to the divider twice.
                    if (r_dvd_valid && div_dividend_tready) begin
                        r_dvd_valid <= 1'b0;
                        r_dvd_sent  <= 1'b1;
                    end
                    if (r_dvs_valid && div_divisor_tready) begin
                        r_dvs_valid <= 1'b0;
                        r_dvs_sent  <= 1'b1;
                    end
                    if (r_dvd_sent && r_dvs_sent) begin
                        r_dvd_sent <= 1'b0;
                        r_dvs_sent <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (div_dout_tvalid) begin
                        case (r_k)
                            2'd0:    r_mx <= w_sat_val;
                            2'd1:    r_my <= w_sat_val;
                            default: r_mz <= w_sat_val;
                        endcase
                        if (r_k == 2'd2) begin
                            r_m_valid <= 1'b1;
                            r_state   <= ST_OUTPUT;
                        end else begin
                            r_k         <= r_k + 2'd1;
                            r_dvd_valid <= 1'b1;
                            r_dvs_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end

                ST_OUTPUT: begin
                    if (m_tready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/persp_divide.md
Name: persp_divide

Overview:
- Perspective-divide stage sitting directly upstream of the shared `Divider` core (AXI-stream dividend/divisor/dout).
- Accepts one homogeneous vertex (x, y, z, w) in signed fixed point and serialises x/w, y/w, z/w through the divider.
- Saturates each quotient back to the fixed-point word and emits (x', y', z') on an output stream to the rasteriser setup stage.

Parameters:
- WIDTH, 32, fixed-point word width (signed).
- FRAC_BITS, 16, fractional bits (Q16.16 by default).
- DIVIDEND_W, 48, divider dividend/quotient width; must equal WIDTH+FRAC_BITS.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_tvalid  in  1  input vertex valid
- s_tready  out  1  input vertex ready
- s_x, s_y, s_z, s_w  in  WIDTH each  input coordinates, signed fixed
- div_dividend_tvalid  out  1  to divider
- div_dividend_tready  in  1  from divider
- div_dividend_tdata  out  DIVIDEND_W  numerator, pre-shifted
- div_divisor_tvalid  out  1  to divider
- div_divisor_tready  in  1  from divider
- div_divisor_tdata  out  WIDTH  w
- div_dout_tvalid  in  1  quotient valid
- div_dout_tready  out  1  quotient ready
- div_dout_tdata  in  DIVIDEND_W  signed quotient
- m_tvalid  out  1  result valid
- m_tready  in  1  result ready
- m_x, m_y, m_z  out  WIDTH each  divided coordinates

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, OUTPUT; index k in 0..2 selects x, y, z.
- Reset (async, aresetn=0):
  - state=IDLE, k=0.
  - div_*_tvalid=0, m_tvalid=0.
  - m_x/m_y/m_z=0, sent flags cleared.
- s_tready=1 only in IDLE.

IDLE:
- On s_tvalid&s_tready, latch x, y, z, w.
- If w==0, go to OUTPUT directly with the zero-divide rule (below); no divider transactions occur.
- Otherwise go to ISSUE with k=0.

ISSUE:
- Drive dividend = sign-extend(coord[k]) << FRAC_BITS, divisor = w.
- Each channel's tvalid is held high until its own valid&ready handshake, tracked by a per-channel sent flag; a channel is never presented twice.
- When both flags are set, clear them and go to WAIT (earliest: the cycle after both handshakes).
- tdata is stable while tvalid=1.

WAIT:
- On div_dout_tvalid&div_dout_tready, saturate the quotient:
  - if q > 2^(WIDTH-1)-1, use MAX;
  - if q < -2^(WIDTH-1), use MIN;
  - else take the low WIDTH bits.
- Store the saturated value into result[k].
- If k<2: k++, go to ISSUE. If k==2: go to OUTPUT.
- Quotient rounding is truncation toward zero, as the divider provides.

OUTPUT:
- m_tvalid=1; m_x/m_y/m_z stable until m_tready.
- On handshake: m_tvalid=0, go to IDLE.

div_dout_tready:
- Asserted in IDLE, ISSUE and WAIT; deasserted in OUTPUT.
- A quotient arriving outside WAIT is discarded. This drains a stale result left by a reset mid-division; the divider holds at most one operation, so ordering is preserved.

Zero-divide rule (w==0), per coordinate:
- positive → MAX (0x7FFFFFFF);
- negative → MIN (0x80000000);
- zero → 0.

Other boundary rules:
- Reset mid-operation: all state is abandoned, the latched vertex is lost, and the divider is not reset by this block.
- Simultaneous m_tready and new s_tvalid: no overlap; the new vertex is accepted from IDLE the next cycle.
- Throughput: one vertex per 3 divider round trips + 2 cycles minimum.

Optional Feature:
- Macro PERSP_DIVIDE_SAT_FLAG_EN.
- Defined:
  - adds output port m_sat [2:0], qualified by m_tvalid.
  - bit k=1 if coordinate k was clamped, by saturation or by the zero-divide rule (a zero numerator with w==0 sets no flag).
  - cleared on reset and at each new vertex accept.
- Undefined:
  - port absent; no flag logic.
  - datapath behaviour identical.

Test Plan:
1. Nominal: x=0x00020000 (2.0), y=0xFFFD0000 (-3.0), z=0x00010000, w=0x00020000, m_tready=1 → m_x=0x00010000, m_y=0xFFFE8000, m_z=0x00008000; exactly 3 dividend and 3 divisor handshakes.
2. Saturation: x=0x7FFF0000, y=0x80010000, z=0, w=0x00000100 → m_x=0x7FFFFFFF, m_y=0x80000000, m_z=0; with macro defined, m_sat=3'b011.
3. Zero divide: x=5.0, y=-5.0, z=0, w=0 → m_x=0x7FFFFFFF, m_y=0x80000000, m_z=0; zero divider tvalid cycles; m_tvalid high within 2 cycles of accept.
4. Split handshake: hold div_dividend_tready=0 for 4 cycles while div_divisor_tready=1 → divisor handshake occurs once, dividend later; results equal to test 1.
5. Backpressure: m_tready=0 for 10 cycles → m_* stable, s_tready=0 throughout; release → one handshake, then s_tready=1.
6. Reset mid-op: assert aresetn=0 in WAIT for k=1 → m_tvalid=0 immediately; after release, stale quotient discarded; next vertex (test 1 values) produces correct results.
